// File: rtl/uart_receiver_16.sv
// Receives 16-bit words as two back-to-back 8N1 UART frames (high byte first) from an async serial line.
// Latency: 2-cycle synchronizer; data/valid update one clock after the second stop bit is sampled.
// No backpressure: each valid is a single-cycle pulse and the next word simply overwrites data.
module uart_receiver_16 #(
  parameter int clock_frequency     = 50000000,
  parameter int baud_rate           = 9600,
  parameter int clock_cycles_in_bit = clock_frequency / baud_rate
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  output logic [15:0] data,
  output logic        valid,
  output logic        busy,
  output logic        framing_error
);

  // Wide enough for the longest interval counted (the inter-frame gap), so no wrap mid-frame.
  localparam int CW = $clog2(4 * clock_cycles_in_bit + 1);
  localparam logic [CW-1:0] L_HALF_LAST = CW'(clock_cycles_in_bit / 2 - 1);
  localparam logic [CW-1:0] L_BIT_LAST  = CW'(clock_cycles_in_bit - 1);
  localparam logic [CW-1:0] L_GAP_LAST  = CW'(4 * clock_cycles_in_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2, r_rx_prev;
  logic [1:0]    r_fill;
  logic          r_armed;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic          r_second, w_second_nxt;
  logic [7:0]    r_shift, r_byte0;
  logic [15:0]   r_data;
  logic          r_valid, r_err;

  logic w_rx_s, w_fall;
  logic w_shift_en, w_load_byte0, w_load_data, w_err, w_disarm;

  assign w_rx_s = r_sync2;
  assign w_fall = r_rx_prev & ~w_rx_s;

  assign data          = r_data;
  assign valid         = r_valid;
  assign framing_error = r_err;
  assign busy          = (r_state != S_IDLE);

  // Synchronizer and re-arm tracking: r_fill marks when rx_s carries a real sample rather than the
  // reset value, so a line held low across reset release is never mistaken for a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_fill    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_fill    <= {r_fill[0], 1'b1};
      if (w_disarm)
        r_armed <= 1'b0;
      else if (w_rx_s && r_fill[1])
        r_armed <= 1'b1;
    end
  end

  // State, counters and byte assembly registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_second <= 1'b0;
      r_shift  <= '0;
      r_byte0  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_second <= w_second_nxt;
      if (w_shift_en)
        r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_load_byte0)
        r_byte0 <= r_shift;
    end
  end

  // Output registers: data only changes on a good second stop bit; pulses last one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_load_data;
      r_err   <= w_err;
      if (w_load_data)
        r_data <= {r_byte0, r_shift};
    end
  end

  // Next-state logic: counter free-runs within a state and is cleared at every sample point.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_bit_nxt    = r_bit;
    w_second_nxt = r_second;
    w_shift_en   = 1'b0;
    w_load_byte0 = 1'b0;
    w_load_data  = 1'b0;
    w_err        = 1'b0;
    w_disarm     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall && r_armed) begin
          w_state_nxt  = S_START;
          w_bit_nxt    = '0;
          w_second_nxt = 1'b0;
        end
      end
      S_START: begin
        if (r_cnt == L_HALF_LAST) begin
          w_cnt_nxt   = '0;
          // A line back high at mid-start-bit is a glitch: drop it silently.
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == L_BIT_LAST) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          if (r_bit == 3'd7)
            w_state_nxt = S_STOP;
          else
            w_bit_nxt = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (r_cnt == L_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_err       = 1'b1;
            w_disarm    = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_second) begin
            w_load_data = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load_byte0 = 1'b1;
            w_second_nxt = 1'b1;
            w_state_nxt  = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_fall) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end else if (r_cnt == L_GAP_LAST) begin
          // Second frame never started: the held first byte is abandoned.
          w_cnt_nxt   = '0;
          w_err       = 1'b1;
          w_disarm    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver_16.sv
module tb_uart_receiver_16;
  localparam int C = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [15:0] data;
  logic        valid;
  logic        busy;
  logic        framing_error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int err_cyc = 0;
  int stop_cyc = 0;
  int exp_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_receiver_16 #(.clock_cycles_in_bit(C)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .busy          (busy),
    .framing_error (framing_error)
  );

  // Scoreboard side: every valid pops the oldest expected word, every error consumes one expected error.
  always @(negedge clock) begin
    if (valid && framing_error) begin
      tests++;
      fails++;
      $display("FAIL valid_and_error_together valid=%b framing_error=%b required not both", valid, framing_error);
    end
    if (valid) begin
      n_valid++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid data=%h required no valid pulse", data);
      end else begin
        exp_v = exp_q.pop_front();
        if (data !== exp_v) begin
          fails++;
          $display("FAIL word_data got=%h required=%h", data, exp_v);
        end
      end
    end
    if (framing_error) begin
      n_err++;
      err_cyc = cyc;
      tests++;
      if (exp_err == 0) begin
        fails++;
        $display("FAIL unexpected_framing_error at cycle %0d required no error", cyc);
      end else begin
        exp_err--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = stop;
    stop_cyc = cyc;
    tick(C);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic wait_drain();
    for (int i = 0; i < 8 * C && (exp_q.size() != 0 || exp_err != 0); i++)
      tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    tick(3);
    if ({data, valid, busy, framing_error} !== 19'h0) begin
      fails++;
      $display("FAIL reset_outputs got data=%h v=%b b=%b e=%b required all zero", data, valid, busy, framing_error);
    end
    tests++;
    reset_n = 1'b1;
    tick(5);
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_busy got=%b required=0", busy);
    end
    tests++;
  endtask

  task automatic test_single_word();
    int v0;
    v0 = n_valid;
    exp_q.push_back(16'hA53C);
    send_word(16'hA53C);
    wait_drain();
    if (exp_q.size() !== 0 || n_valid !== v0 + 1) begin
      fails++;
      $display("FAIL single_word_count pending=%0d pulses=%0d required pending=0 pulses=1", exp_q.size(), n_valid - v0);
    end
    tests++;
    if (data !== 16'hA53C) begin
      fails++;
      $display("FAIL single_word_hold got=%h required=a53c", data);
    end
    tests++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h1234);
    send_word(16'h0000);
    send_word(16'hFFFF);
    send_word(16'h1234);
    wait_drain();
    if (exp_q.size() !== 0 || n_valid !== v0 + 3) begin
      fails++;
      $display("FAIL back_to_back_count pending=%0d pulses=%0d required pending=0 pulses=3", exp_q.size(), n_valid - v0);
    end
    tests++;
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(10);
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy got=%b required=0", busy);
    end
    tests++;
    tick(2 * C);
    if (n_valid !== v0 || n_err !== e0) begin
      fails++;
      $display("FAIL glitch_outputs pulses=%0d errors=%0d required 0 and 0", n_valid - v0, n_err - e0);
    end
    tests++;
  endtask

  task automatic test_stop_error();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_byte(8'h77, 1'b1);
    exp_err++;
    send_byte(8'h88, 1'b0);
    wait_drain();
    if (n_err !== e0 + 1 || n_valid !== v0) begin
      fails++;
      $display("FAIL stop_error_pulses errors=%0d valids=%0d required 1 and 0", n_err - e0, n_valid - v0);
    end
    tests++;
    if (data !== 16'h1234) begin
      fails++;
      $display("FAIL stop_error_data_held got=%h required=1234", data);
    end
    tests++;
    tick(C);
    exp_q.push_back(16'h5AA5);
    send_word(16'h5AA5);
    wait_drain();
    if (data !== 16'h5AA5 || n_valid !== v0 + 1) begin
      fails++;
      $display("FAIL recover_after_error got=%h pulses=%0d required=5aa5 pulses=1", data, n_valid - v0);
    end
    tests++;
  endtask

  task automatic test_gap_timeout();
    int e0, d;
    e0 = n_err;
    send_byte(8'h3C, 1'b1);
    exp_err++;
    for (int i = 0; i < 6 * C && exp_err != 0; i++)
      tick(1);
    if (n_err !== e0 + 1) begin
      fails++;
      $display("FAIL gap_timeout_pulse errors=%0d required=1", n_err - e0);
    end
    tests++;
    // Stop sample lands 2 (sync) + C/2 + 1 cycles into the stop bit; the error follows 4*C later.
    d = err_cyc - stop_cyc;
    if (d < 4 * C + C / 2 + 1 || d > 4 * C + C / 2 + 5) begin
      fails++;
      $display("FAIL gap_timeout_time got=%0d cycles after stop bit start required=%0d +-2", d, 4 * C + C / 2 + 3);
    end
    tests++;
    tick(2);
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL gap_timeout_busy got=%b required=0", busy);
    end
    tests++;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    logic [7:0] b;
    b = 8'hC3;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = b[3];
    tick(C / 2);
    reset_n = 1'b0;
    tick(1);
    if ({data, valid, busy, framing_error} !== 19'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs got data=%h v=%b b=%b e=%b required all zero", data, valid, busy, framing_error);
    end
    tests++;
    tick(3);
    rx = 1'b1;
    reset_n = 1'b1;
    tick(C);
    v0 = n_valid;
    exp_q.push_back(16'hC3E1);
    send_word(16'hC3E1);
    wait_drain();
    if (data !== 16'hC3E1 || n_valid !== v0 + 1) begin
      fails++;
      $display("FAIL after_reset_word got=%h pulses=%0d required=c3e1 pulses=1", data, n_valid - v0);
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_glitch();
    test_stop_error();
    test_gap_timeout();
    test_reset_mid_frame();
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/uart_receiver_16.md
UART_RECEIVER_16 -- requirements
Module: uart_receiver_16

Interface
REQ-001 The block SHALL have parameter clock_frequency, default 50000000, meaning the clock frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 9600, meaning the serial bit rate in bits per second.
REQ-003 The block SHALL have parameter clock_cycles_in_bit, default clock_frequency / baud_rate, meaning the clock cycles per serial bit (must be >= 8).
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port rx, input, 1 bit, the asynchronous serial line, idle high.
REQ-007 The block SHALL have port data, output, 16 bits, the last complete received word.
REQ-008 The block SHALL have port valid, output, 1 bit, a one-cycle pulse when data is updated.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port framing_error, output, 1 bit, a one-cycle pulse on stop-bit error or inter-byte timeout.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s; input-to-rx_s latency is 2 cycles.
REQ-012 Frame format SHALL be: start bit (0), 8 data bits LSB first, 1 stop bit (1), with no parity.
REQ-013 A word SHALL consist of two consecutive frames: first frame goes to data[15:8], second frame goes to data[7:0].
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, GAP.
REQ-015 IDLE SHALL move to START on rx_s 1->0 (falling edge) and clear the bit counter, but only if rx_s has been high at least one cycle since reset or since the last abort.
REQ-016 START SHALL wait clock_cycles_in_bit/2 cycles (integer division), then sample rx_s: if 0, move to DATA; if 1 (false start), move to IDLE with no error pulse.
REQ-017 DATA SHALL sample rx_s every clock_cycles_in_bit cycles, at bit centre, into a shift register LSB first, and move to STOP after the 8th sample.
REQ-018 STOP SHALL sample rx_s clock_cycles_in_bit cycles after the 8th data sample.
REQ-019 In STOP with stop = 1 on the first frame, the first byte SHALL be latched internally and the FSM SHALL move to GAP.
REQ-020 In STOP with stop = 1 on the second frame, data SHALL load {byte0, byte1} and valid SHALL pulse for exactly 1 cycle on the next clock edge; the FSM SHALL then return to IDLE.
REQ-021 In STOP with stop = 0, framing_error SHALL pulse for 1 cycle, the partial word SHALL be discarded with data unchanged, and the FSM SHALL move to IDLE, which then requires rx_s high before re-arming.
REQ-022 GAP SHALL move to START on a falling edge of rx_s.
REQ-023 If no falling edge arrives within 4*clock_cycles_in_bit cycles of the stop sample, GAP SHALL pulse framing_error, discard byte0, and move to IDLE.
REQ-024 Timing counters SHALL be $clog2(4*clock_cycles_in_bit+1) bits wide and SHALL never wrap during a frame.
REQ-025 data SHALL hold its value between valid pulses; valid and framing_error SHALL never be high in the same cycle.
REQ-026 The receiver SHALL accept back-to-back words, with the next word's start bit immediately after the second stop bit, and lose none.

Reset
REQ-027 While reset_n = 0, the block SHALL hold: state IDLE, data 16'h0000, valid 0, busy 0, framing_error 0, synchronizer flops 1, counters 0.
REQ-028 Reset assertion mid-frame SHALL abort immediately; after release, the receiver SHALL require rx_s high before accepting a start bit.

Verification
REQ-029 With clock_cycles_in_bit = 16, send word 16'hA53C as two frames back-to-back -> one valid pulse, data = 16'hA53C, framing_error never asserted.
REQ-030 Send 3 consecutive words 16'h0000, 16'hFFFF, 16'h1234 with no idle gap -> three valid pulses, in order, with the matching data.
REQ-031 Hold rx low for 5 cycles then release, a glitch shorter than 8 cycles -> no valid, no error, busy returns to 0 by cycle 10.
REQ-032 Send the second frame with stop bit = 0 -> framing_error pulses once, valid stays 0, data retains its previous value; a following good 16'h5AA5 is received correctly.
REQ-033 Send only the first frame of a word, then idle high -> framing_error pulses 4*16 cycles after the stop sample, and busy = 0 afterwards.
REQ-034 Assert reset_n = 0 during the 4th data bit of the first frame, then send 16'hC3E1 -> all outputs at reset values during reset, and data = 16'hC3E1 with one valid pulse afterwards.
